// File: rtl/hec_pkg.sv
// rtl/hec_pkg.sv - shared constants for the header-error-check sequencer and LFSR
package hec_pkg;

    localparam int HEC_W        = 8;
    localparam int HDR_BITS_DEF = 10;

    // Generator D^8 + D^7 + D^5 + D^2 + D + 1, D^8 term implied by the feedback
    localparam logic [HEC_W-1:0] HEC_POLY = 8'hA7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_HEC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/hec.sv
// rtl/hec.sv - 8-bit HEC LFSR: seed load, header feed, remainder drain
module hec
    import hec_pkg::*;
(
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             loadini_p,
    input  logic [HEC_W-1:0] hecremini,
    input  logic             shift_in,
    input  logic             shift_out,
    input  logic             datvalid_p,
    input  logic             hec_datin,
    output logic [HEC_W-1:0] hecrem
);

    logic [HEC_W-1:0] rem_q;
    logic [HEC_W-1:0] rem_d;
    logic             fb;

    assign fb = rem_q[HEC_W-1] ^ hec_datin;

    always_comb begin
        rem_d = rem_q;
        if (loadini_p) begin
            rem_d = hecremini;
        end else if (datvalid_p && shift_in) begin
            rem_d = {rem_q[HEC_W-2:0], 1'b0} ^ (fb ? HEC_POLY : '0);
        end else if (datvalid_p && shift_out) begin
            rem_d = {rem_q[HEC_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign hecrem = rem_q;

endmodule

// File: rtl/hec_seq_ctrl.sv
// rtl/hec_seq_ctrl.sv - per-header sequencer for the HEC LFSR (TX generate / RX check)
module hec_seq_ctrl
    import hec_pkg::*;
#(
    parameter int HDR_BITS = HDR_BITS_DEF
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             start_tx_p,
    input  logic             start_rx_p,
    input  logic             abort_p,
    input  logic [HEC_W-1:0] uap,
    input  logic             bit_p,
    input  logic             bit_in,
    input  logic [HEC_W-1:0] hecrem,
    output logic             loadini_p,
    output logic [HEC_W-1:0] hecremini,
    output logic             shift_in,
    output logic             shift_out,
    output logic             datvalid_p,
    output logic             hec_datin,
    output logic             tx_bit,
    output logic             tx_bit_vld,
    output logic             busy,
    output logic             done_p,
    output logic             hec_ok
);

    localparam logic [3:0] HDR_LAST = 4'(HDR_BITS - 1);
    localparam logic [3:0] HEC_LAST = 4'(HEC_W - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             mode_rx_q, mode_rx_d;
    logic [HEC_W-1:0] uap_q, uap_d;
    logic             mism_q, mism_d;
    logic             hec_ok_q, hec_ok_d;

    logic             in_hdr, in_hec, strobe;
    logic [HEC_W-2:0] unused_hecrem;

    assign unused_hecrem = hecrem[HEC_W-2:0];
    assign in_hdr = (state_q == ST_HDR);
    assign in_hec = (state_q == ST_HEC);
    // An abort cycle must never clock the LFSR, even if a strobe coincides
    assign strobe = bit_p & ~abort_p;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_rx_d = mode_rx_q;
        uap_d     = uap_q;
        mism_d    = mism_q;
        hec_ok_d  = hec_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (!abort_p && (start_tx_p || start_rx_p)) begin
                    mode_rx_d = ~start_tx_p;
                    uap_d     = uap;
                    mism_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort_p ? ST_IDLE : ST_HDR;
            end
            ST_HDR: begin
                if (abort_p) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bit_p) begin
                    if (cnt_q == HDR_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_HEC;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_HEC: begin
                if (abort_p) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bit_p) begin
                    mism_d = mism_q | (mode_rx_q & (bit_in ^ hecrem[HEC_W-1]));
                    if (cnt_q == HEC_LAST) begin
                        cnt_d    = '0;
                        state_d  = ST_DONE;
                        hec_ok_d = mode_rx_q ? ~mism_d : 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_rx_q <= 1'b0;
            uap_q     <= '0;
            mism_q    <= 1'b0;
            hec_ok_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_rx_q <= mode_rx_d;
            uap_q     <= uap_d;
            mism_q    <= mism_d;
            hec_ok_q  <= hec_ok_d;
        end
    end

    assign loadini_p  = (state_q == ST_LOAD);
    assign hecremini  = uap_q;
    assign shift_in   = in_hdr & strobe;
    assign shift_out  = in_hec & strobe;
    assign datvalid_p = (in_hdr | in_hec) & strobe;
    assign hec_datin  = in_hdr & bit_in;
    assign tx_bit     = ~mode_rx_q & ((in_hdr & bit_in) | (in_hec & hecrem[HEC_W-1]));
    assign tx_bit_vld = ~mode_rx_q & (in_hdr | in_hec) & strobe;
    assign busy       = (state_q != ST_IDLE);
    assign done_p     = (state_q == ST_DONE) & ~abort_p;
    assign hec_ok     = hec_ok_q;

endmodule

// File: tb/tb_hec_seq_ctrl.sv
// tb/tb_hec_seq_ctrl.sv - directed self-checking bench for hec_seq_ctrl beside hec
module tb_hec_seq_ctrl;

    logic       clk_6M = 1'b0;
    logic       rst = 1'b1;
    logic       start_tx_p = 1'b0, start_rx_p = 1'b0, abort_p = 1'b0;
    logic [7:0] uap = 8'h00;
    logic       bit_p = 1'b0, bit_in = 1'b0;
    logic [7:0] hecrem, hecremini;
    logic       loadini_p, shift_in, shift_out, datvalid_p, hec_datin;
    logic       tx_bit, tx_bit_vld, busy, done_p, hec_ok;

    int n_vec = 0;
    int n_err = 0;

    int   n_vld = 0, n_done = 0, n_dv = 0, n_ld = 0;
    logic txbits [0:1023];
    logic [7:0] ld_seed = 8'h00;

    always #5 clk_6M = ~clk_6M;

    hec_seq_ctrl #(.HDR_BITS(10)) dut (
        .clk_6M(clk_6M), .rst(rst), .start_tx_p(start_tx_p), .start_rx_p(start_rx_p),
        .abort_p(abort_p), .uap(uap), .bit_p(bit_p), .bit_in(bit_in), .hecrem(hecrem),
        .loadini_p(loadini_p), .hecremini(hecremini), .shift_in(shift_in),
        .shift_out(shift_out), .datvalid_p(datvalid_p), .hec_datin(hec_datin),
        .tx_bit(tx_bit), .tx_bit_vld(tx_bit_vld), .busy(busy), .done_p(done_p),
        .hec_ok(hec_ok)
    );

    hec u_hec (
        .clk_6M(clk_6M), .rst(rst), .loadini_p(loadini_p), .hecremini(hecremini),
        .shift_in(shift_in), .shift_out(shift_out), .datvalid_p(datvalid_p),
        .hec_datin(hec_datin), .hecrem(hecrem)
    );

    always @(posedge clk_6M) begin
        if (tx_bit_vld) begin
            txbits[n_vld[9:0]] <= tx_bit;
            n_vld <= n_vld + 1;
        end
        if (done_p) n_done <= n_done + 1;
        if (datvalid_p) n_dv <= n_dv + 1;
        if (loadini_p) begin
            n_ld    <= n_ld + 1;
            ld_seed <= hecremini;
        end
    end

    // Reference LFSR: D^8+D^7+D^5+D^2+D+1, header bits fed hdr[0] first
    function automatic logic [7:0] hec_model(input logic [7:0] seed, input logic [9:0] hdr);
        logic [7:0] r;
        logic       fb;
        r = seed;
        for (int i = 0; i < 10; i++) begin
            fb = r[7] ^ hdr[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic start(input logic tx, input logic rx, input logic [7:0] seed);
        tick();
        start_tx_p = tx;
        start_rx_p = rx;
        uap        = seed;
        tick();
        start_tx_p = 1'b0;
        start_rx_p = 1'b0;
        uap        = 8'hFF;
    endtask

    task automatic strobe(input logic b);
        repeat (5) @(posedge clk_6M);
        #1;
        bit_p  = 1'b1;
        bit_in = b;
        tick();
        bit_p  = 1'b0;
        bit_in = 1'b0;
    endtask

    logic [7:0] last_hec;

    task automatic run_hdr(input string tag, input logic tx, input logic rx,
                           input logic [7:0] seed, input logic [9:0] hdr,
                           input logic [7:0] hecv, input logic ld_strobe,
                           input logic poke, input logic exp_ok);
        int         vb, db, lb;
        logic       is_rx;
        logic [9:0] got_hdr;
        vb    = n_vld;
        db    = n_done;
        lb    = n_ld;
        is_rx = rx & ~tx;
        start(tx, rx, seed);
        if (ld_strobe) begin
            bit_p  = 1'b1;
            bit_in = 1'b1;
            tick();
            bit_p  = 1'b0;
            bit_in = 1'b0;
        end
        for (int i = 0; i < 10; i++) strobe(hdr[i]);
        for (int i = 0; i < 8; i++) begin
            strobe(is_rx ? hecv[7-i] : 1'b0);
            if (poke && i == 1) begin
                start_rx_p = 1'b1;
                tick();
                start_rx_p = 1'b0;
            end
        end
        chk({tag, " done_p"}, done_p, 1);
        chk({tag, " hec_ok"}, hec_ok, exp_ok);
        tick();
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " done_count"}, n_done - db, 1);
        chk({tag, " load_count"}, n_ld - lb, 1);
        chk({tag, " load_seed"}, ld_seed, seed);
        chk({tag, " vld_count"}, n_vld - vb, is_rx ? 0 : 18);
        if (!is_rx) begin
            for (int i = 0; i < 10; i++) got_hdr[i] = txbits[vb + i];
            for (int i = 0; i < 8; i++) last_hec[7-i] = txbits[vb + 10 + i];
            chk({tag, " tx_header"}, got_hdr, hdr);
            chk({tag, " tx_hec"}, last_hec, hec_model(seed, hdr));
        end
    endtask

    localparam logic [9:0] HDR_A = 10'b10_1100_1110;
    localparam logic [9:0] HDR_B = 10'b01_0011_0101;

    initial begin
        logic [7:0] hec_a;
        int         db, dvb;
        repeat (3) @(posedge clk_6M);
        #1 rst = 1'b0;

        chk("rst busy", busy, 0);
        chk("rst done_p", done_p, 0);
        chk("rst hec_ok", hec_ok, 1);
        chk("rst loadini_p", loadini_p, 0);
        chk("rst hecremini", hecremini, 0);
        chk("rst shift", {shift_in, shift_out, datvalid_p, tx_bit_vld, tx_bit}, 0);

        run_hdr("tx_zero", 1, 0, 8'h00, 10'h000, 8'h00, 0, 0, 1);
        chk("tx_zero hec_value", last_hec, 8'h00);

        run_hdr("tx_47", 1, 0, 8'h47, HDR_A, 8'h00, 0, 0, 1);
        hec_a = last_hec;
        run_hdr("rx_clean", 0, 1, 8'h47, HDR_A, hec_a, 0, 0, 1);
        run_hdr("rx_bit3", 0, 1, 8'h47, HDR_A, hec_a ^ 8'h08, 0, 0, 0);
        run_hdr("rx_clean2", 0, 1, 8'h47, HDR_A, hec_a, 0, 0, 1);
        run_hdr("rx_bit3b", 0, 1, 8'h47, HDR_A, hec_a ^ 8'h08, 0, 0, 0);

        // Abort after the 4th header strobe, coinciding with a fifth strobe
        db = n_done;
        start(1, 0, 8'h12);
        for (int i = 0; i < 4; i++) strobe(HDR_B[i]);
        repeat (5) @(posedge clk_6M);
        #1;
        abort_p = 1'b1;
        bit_p   = 1'b1;
        #1;
        chk("abort no_strobe", {datvalid_p, shift_in, shift_out, tx_bit_vld}, 0);
        tick();
        abort_p = 1'b0;
        bit_p   = 1'b0;
        chk("abort busy", busy, 0);
        dvb = n_dv;
        for (int i = 0; i < 5; i++) strobe(1'b1);
        chk("abort no_shift", n_dv - dvb, 0);
        chk("abort no_done", n_done - db, 0);
        chk("abort hec_ok_kept", hec_ok, 0);
        run_hdr("tx_after_abort", 1, 0, 8'h12, HDR_B, 8'h00, 0, 0, 1);

        // Reset in the middle of the HEC phase
        run_hdr("rx_bit3c", 0, 1, 8'h47, HDR_A, hec_a ^ 8'h08, 0, 0, 0);
        start(1, 0, 8'h47);
        for (int i = 0; i < 10; i++) strobe(HDR_A[i]);
        for (int i = 0; i < 3; i++) strobe(1'b0);
        chk("pre_rst busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst hec_ok", hec_ok, 1);
        chk("midrst outs", {loadini_p, shift_in, shift_out, datvalid_p, tx_bit, tx_bit_vld, done_p}, 0);
        chk("midrst hecremini", hecremini, 0);
        run_hdr("tx_ld_strobe", 1, 0, 8'h47, HDR_A, 8'h00, 1, 0, 1);

        run_hdr("tx_poke_rx", 1, 0, 8'h5C, HDR_B, 8'h00, 0, 1, 1);
        run_hdr("tx_both", 1, 1, 8'hA3, HDR_A, 8'h00, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
